// File: rtl/posit_pack_round_8_es3.sv
// Final pack stage of the es3 posit-8 adder: encodes regime/exponent, clips,
// rounds to nearest even and applies the sign, as a 3-stage valid/ready pipeline.
module posit_pack_round_8_es3 #(
  parameter int NBITS   = 8,
  parameter int ES      = 3,
  parameter int SCALE_W = 9,
  parameter int FBITS   = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1+SCALE_W+FBITS+2-1:0]  in_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NBITS-1:0]              out_posit,
  output logic                          out_nar,
  output logic                          out_zero
);

  localparam int SUM_W = 1 + SCALE_W + FBITS + 2;
  // Padding below the fraction keeps every shifted-out bit visible to sticky.
  localparam int VW    = 2 + ES + FBITS + NBITS;
  localparam int MAXSC = (NBITS - 2) << ES;
  localparam logic signed [SCALE_W-1:0] SC_HI = SCALE_W'(MAXSC);
  localparam logic signed [SCALE_W-1:0] SC_LO = SCALE_W'(-MAXSC);
  localparam logic [NBITS-2:0] MAXPOS = {(NBITS-1){1'b1}};
  localparam logic [NBITS-2:0] MINPOS = {{(NBITS-2){1'b0}}, 1'b1};
  localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};

  logic w_stall, w_adv;
  assign w_stall  = out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;

  // Stage 1: decode
  logic                      w_sgn, w_inf, w_zero;
  logic signed [SCALE_W-1:0] w_scale, w_k;
  logic [ES-1:0]             w_e;
  logic [FBITS-1:0]          w_frac;
  logic                      w_clip_hi, w_clip_lo;

  assign w_sgn     = in_sum[SUM_W-1];
  assign w_scale   = $signed(in_sum[SUM_W-2 -: SCALE_W]);
  assign w_frac    = in_sum[FBITS+1:2];
  assign w_inf     = in_sum[1];
  assign w_zero    = in_sum[0];
  assign w_k       = w_scale >>> ES;
  assign w_e       = w_scale[ES-1:0];
  assign w_clip_hi = (w_scale >= SC_HI);
  assign w_clip_lo = (w_scale < SC_LO);

  logic                      r_v1, r_sgn1, r_inf1, r_zero1, r_chi1, r_clo1;
  logic signed [SCALE_W-1:0] r_k1;
  logic [ES-1:0]             r_e1;
  logic [FBITS-1:0]          r_frac1;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_sgn1  <= w_sgn;
      r_inf1  <= w_inf;
      r_zero1 <= w_zero;
      r_chi1  <= w_clip_hi;
      r_clo1  <= w_clip_lo;
      r_k1    <= w_k;
      r_e1    <= w_e;
      r_frac1 <= w_frac;
    end
  end

  // Stage 2: assemble. An arithmetic shift of {lead, ~lead, ...} replicates the
  // lead bit, giving k+1 ones then 0 (k>=0) or -k zeros then 1 (k<0).
  logic                  w_lead;
  logic [SCALE_W-1:0]    w_sh;
  logic [VW-1:0]         w_pre, w_vec;
  logic [NBITS-2:0]      w_body;
  logic                  w_bafter, w_sticky;

  assign w_lead   = ~r_k1[SCALE_W-1];
  assign w_sh     = r_k1[SCALE_W-1] ? ~r_k1 : r_k1;
  assign w_pre    = {w_lead, ~w_lead, r_e1, r_frac1, {NBITS{1'b0}}};
  assign w_vec    = $signed(w_pre) >>> w_sh;
  assign w_body   = w_vec[VW-1 -: NBITS-1];
  assign w_bafter = w_vec[VW-NBITS];
  assign w_sticky = |w_vec[VW-NBITS-1:0];

  logic             r_v2, r_sgn2, r_inf2, r_zero2, r_chi2, r_clo2;
  logic             r_bafter2, r_sticky2;
  logic [NBITS-2:0] r_body2;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_sgn2    <= r_sgn1;
      r_inf2    <= r_inf1;
      r_zero2   <= r_zero1;
      r_chi2    <= r_chi1;
      r_clo2    <= r_clo1;
      r_body2   <= w_body;
      r_bafter2 <= w_bafter;
      r_sticky2 <= w_sticky;
    end
  end

  // Stage 3: round, clip, sign, specials
  logic             w_up;
  logic [NBITS-1:0] w_rnd;
  logic [NBITS-2:0] w_mag;
  logic [NBITS-1:0] w_pos;
  logic [NBITS-1:0] w_posit;
  logic             w_nar, w_zr;

  assign w_up  = r_bafter2 & (r_body2[0] | r_sticky2);
  assign w_rnd = {1'b0, r_body2} + {{(NBITS-1){1'b0}}, w_up};

  always_comb begin
    w_mag = w_rnd[NBITS-2:0];
    if (r_chi2)
      w_mag = MAXPOS;
    else if (r_clo2)
      w_mag = MINPOS;
    else if (w_rnd[NBITS-1])
      w_mag = MAXPOS;
    else if (w_rnd[NBITS-2:0] == '0)
      w_mag = MINPOS;
  end

  assign w_pos = {1'b0, w_mag};

  always_comb begin
    w_posit = r_sgn2 ? (~w_pos + 1'b1) : w_pos;
    w_nar   = 1'b0;
    w_zr    = 1'b0;
    if (r_inf2) begin
      w_posit = NAR;
      w_nar   = 1'b1;
    end else if (r_zero2) begin
      w_posit = '0;
      w_zr    = 1'b1;
    end
  end

  logic             r_v3, r_nar3, r_zero3;
  logic [NBITS-1:0] r_posit3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_posit3 <= '0;
      r_nar3   <= 1'b0;
      r_zero3  <= 1'b0;
    end else if (w_adv) begin
      r_v1     <= in_valid;
      r_v2     <= r_v1;
      r_v3     <= r_v2;
      r_posit3 <= w_posit;
      r_nar3   <= w_nar;
      r_zero3  <= w_zr;
    end
  end

  assign out_valid = r_v3;
  assign out_posit = r_posit3;
  assign out_nar   = r_nar3;
  assign out_zero  = r_zero3;

endmodule

// File: tb/tb_posit_pack_round_8_es3.sv
// Scoreboard bench for posit_pack_round_8_es3: directed vectors with
// hand-computed posits, backpressure, and mid-flight reset.
module tb_posit_pack_round_8_es3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [41:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_posit;
  logic        out_nar;
  logic        out_zero;

  always #5 clk = ~clk;

  posit_pack_round_8_es3 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_nar(out_nar), .out_zero(out_zero)
  );

  int errors = 0;
  int checks = 0;
  logic [9:0] q[$];
  logic       stalled_prev = 1'b0;
  logic [9:0] held;
  logic [9:0] mon_exp;
  int         stall_seen = 0;

  function automatic logic [41:0] mk(input logic s, input logic [8:0] sc,
                                     input logic [29:0] f, input logic inf,
                                     input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [9:0] ex(input logic [7:0] p, input logic n, input logic z);
    return {p, n, z};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (stalled_prev)
        chk("stall_stable", {out_valid, out_posit, out_nar, out_zero}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_posit);
        end else begin
          mon_exp = q.pop_front();
          chk("result", {out_posit, out_nar, out_zero}, mon_exp);
        end
      end
      if (out_valid && !out_ready) stall_seen++;
      stalled_prev = out_valid && !out_ready;
      held = {out_posit, out_nar, out_zero};
    end
  end

  task automatic send(input logic [41:0] s, input logic [9:0] e);
    bit ok = 0;
    in_valid = 1'b1;
    in_sum   = s;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  int lat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_outs", {out_posit, out_nar, out_zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(mk(0, 9'd0,   30'h0,        0, 0), ex(8'h40, 0, 0));
    send(mk(1, 9'd0,   30'h0,        0, 0), ex(8'hC0, 0, 0));
    send(mk(0, 9'd0,   30'b110 << 27, 0, 0), ex(8'h43, 0, 0));
    send(mk(0, 9'd0,   30'b001 << 27, 0, 0), ex(8'h40, 0, 0));
    send(mk(0, 9'd0,   30'b011 << 27, 0, 0), ex(8'h42, 0, 0));
    send(mk(0, 9'd0,   30'b0011 << 26, 0, 0), ex(8'h41, 0, 0));
    send(mk(1, 9'd0,   30'b110 << 27, 0, 0), ex(8'hBD, 0, 0));
    send(mk(0, 9'd8,   30'h0,        0, 0), ex(8'h60, 0, 0));
    send(mk(1, 9'd8,   30'h0,        0, 0), ex(8'hA0, 0, 0));
    send(mk(0, 9'd48,  30'h0,        0, 0), ex(8'h7F, 0, 0));
    send(mk(0, 9'd47,  30'h0,        0, 0), ex(8'h7F, 0, 0));
    send(mk(0, 9'h1C4, 30'h0,        0, 0), ex(8'h01, 0, 0));
    send(mk(0, 9'h1D0, 30'h0,        0, 0), ex(8'h01, 0, 0));
    send(mk(1, 9'h064, 30'h0,        0, 0), ex(8'h81, 0, 0));
    send(mk(0, 9'h1FF, 30'h0,        0, 0), ex(8'h3C, 0, 0));
    send(mk(0, 9'h1F7, 30'h0,        0, 0), ex(8'h1E, 0, 0));
    send(mk(1, 9'd5,   30'h3,        1, 1), ex(8'h80, 1, 0));
    send(mk(1, 9'd5,   30'h3,        0, 1), ex(8'h00, 0, 1));
    drain();

    // backpressure: six back-to-back items, consumer stalls for five cycles
    fork
      begin
        send(mk(0, 9'd0,  30'h0, 0, 0), ex(8'h40, 0, 0));
        send(mk(0, 9'd8,  30'h0, 0, 0), ex(8'h60, 0, 0));
        send(mk(1, 9'd0,  30'h0, 0, 0), ex(8'hC0, 0, 0));
        send(mk(0, 9'd48, 30'h0, 0, 0), ex(8'h7F, 0, 0));
        send(mk(0, 9'd0,  30'h0, 0, 1), ex(8'h00, 0, 1));
        send(mk(0, 9'h1FF, 30'h0, 0, 0), ex(8'h3C, 0, 0));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_observed", 32'(stall_seen > 0), 1);

    // reset with three items in flight
    send(mk(0, 9'd0, 30'h0, 0, 0), ex(8'h40, 0, 0));
    send(mk(0, 9'd8, 30'h0, 0, 0), ex(8'h60, 0, 0));
    send(mk(1, 9'd0, 30'h0, 0, 0), ex(8'hC0, 0, 0));
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("flush_valid", 32'(out_valid), 0);

    in_valid = 1'b1;
    in_sum   = mk(0, 9'd0, 30'b110 << 27, 0, 0);
    chk("post_rst_ready", 32'(in_ready), 1);
    q.push_back(ex(8'h43, 0, 0));
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    chk("latency", lat, 3);
    repeat (6) @(posedge clk);
    #1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
